// File: rtl/pio_irq_servicer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pio_pkg                                                       |
// | Description : Shared definitions for the PIO interrupt servicer: PIO        |
// |               register offsets, servicer FSM state encoding and the         |
// |               per-cycle Avalon-MM command bundle with helper constructors.  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package pio_pkg;

   // PIO register map (word offsets on avm_address)
   localparam logic [1:0] PIO_DATA     = 2'd0;
   localparam logic [1:0] PIO_DIR      = 2'd1;
   localparam logic [1:0] PIO_IRQ_MASK = 2'd2;
   localparam logic [1:0] PIO_EDGE     = 2'd3;

   // Servicer FSM states, explicit 3-bit encoding
   typedef enum logic [2:0] {
      ST_INIT     = 3'd0,
      ST_CLR0     = 3'd1,
      ST_IDLE     = 3'd2,
      ST_RD_EDGE  = 3'd3,
      ST_CAP_EDGE = 3'd4,
      ST_RD_DATA  = 3'd5,
      ST_CAP_DATA = 3'd6,
      ST_PUSH     = 3'd7
   } svc_state_e;

   // One bus cycle worth of master command. wr_mask selects IRQ_MASK as the
   // write payload; every other write, and every read, carries zero data.
   typedef struct packed {
      logic       chipselect;
      logic       write_n;
      logic [1:0] address;
      logic       wr_mask;
   } avm_cmd_t;

   function automatic avm_cmd_t avm_nop();
      avm_cmd_t c;
      c.chipselect = 1'b0;
      c.write_n    = 1'b1;
      c.address    = 2'd0;
      c.wr_mask    = 1'b0;
      return c;
   endfunction

   function automatic avm_cmd_t avm_rd(input logic [1:0] addr);
      avm_cmd_t c;
      c.chipselect = 1'b1;
      c.write_n    = 1'b1;
      c.address    = addr;
      c.wr_mask    = 1'b0;
      return c;
   endfunction

   function automatic avm_cmd_t avm_wr(input logic [1:0] addr, input logic use_mask);
      avm_cmd_t c;
      c.chipselect = 1'b1;
      c.write_n    = 1'b0;
      c.address    = addr;
      c.wr_mask    = use_mask;
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pio_irq_servicer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pio_irq_servicer                                              |
// | Description : Avalon-MM master that services an edge-capturing input PIO    |
// |               from its irq line. After reset it programs the irq mask and   |
// |               clears stale edges, then sleeps. On irq it reads and clears   |
// |               edge_capture, reads the data register and presents            |
// |               {edges, data} as one event on a valid/ready stream.           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                       |
// |   clk              in   system clock                                        |
// |   reset_n          in   asynchronous active-low reset                       |
// |   enable_i         in   gates the start of a new service sequence           |
// |   irq_i            in   PIO interrupt request (level)                       |
// |   avm_address_o    out  PIO register offset                                 |
// |   avm_chipselect_o out  one-cycle access strobe                             |
// |   avm_write_n_o    out  active-low write                                    |
// |   avm_writedata_o  out  write data (zero on reads)                          |
// |   avm_readdata_i   in   read data, valid one cycle after the address        |
// |   evt_valid_o      out  event available                                     |
// |   evt_ready_i      in   downstream accepts event                            |
// |   evt_edges_o      out  edge_capture snapshot                               |
// |   evt_data_o       out  data register snapshot                              |
// |   evt_count_o      out  saturating count of delivered events               |
// |   busy_o           out  high in every state other than IDLE                 |
// +----------------------------------------------------------------------------+
module pio_irq_servicer
   import pio_pkg::*;
#(
   // DATA_WIDTH must lie in 1..32 (it is sliced out of the 32-bit bus)
   parameter int                    DATA_WIDTH = 10,
   parameter logic [DATA_WIDTH-1:0] IRQ_MASK   = 10'h3FF,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable_i,
   input  logic                  irq_i,
   output logic [1:0]            avm_address_o,
   output logic                  avm_chipselect_o,
   output logic                  avm_write_n_o,
   output logic [31:0]           avm_writedata_o,
   input  logic [31:0]           avm_readdata_i,
   output logic                  evt_valid_o,
   input  logic                  evt_ready_i,
   output logic [DATA_WIDTH-1:0] evt_edges_o,
   output logic [DATA_WIDTH-1:0] evt_data_o,
   output logic [CNT_WIDTH-1:0]  evt_count_o,
   output logic                  busy_o
);

   svc_state_e            state_q, state_d;
   avm_cmd_t              bus_cmd;
   logic                  cap_edges;
   logic                  cap_data;

   logic [DATA_WIDTH-1:0] edges_q, edges_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  evt_valid_q, evt_valid_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;

   logic                  handshake;
   logic                  edges_zero;
   logic                  cap_event;

   assign handshake  = evt_valid_q & evt_ready_i;
   assign edges_zero = (edges_q == '0);
   // A zero edge snapshot means the irq was spurious: finish the data read
   // but publish nothing.
   assign cap_event  = cap_data & ~edges_zero;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT:     state_d = ST_CLR0;
         ST_CLR0:     state_d = ST_IDLE;
         ST_IDLE:     if (irq_i && enable_i) state_d = ST_RD_EDGE;
         ST_RD_EDGE:  state_d = ST_CAP_EDGE;
         ST_CAP_EDGE: state_d = ST_RD_DATA;
         ST_RD_DATA:  state_d = ST_CAP_DATA;
         ST_CAP_DATA: state_d = edges_zero ? ST_IDLE : ST_PUSH;
         // irq is deliberately not looked at here: edge_capture is sticky,
         // so anything arriving under backpressure is picked up next pass.
         ST_PUSH:     if (handshake) state_d = ST_IDLE;
         default:     state_d = ST_INIT;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output logic (bus command and capture strobes)
   // ------------------------------------------------------------------
   always_comb begin
      bus_cmd   = avm_nop();
      cap_edges = 1'b0;
      cap_data  = 1'b0;
      case (state_q)
         ST_INIT:     bus_cmd = avm_wr(PIO_IRQ_MASK, 1'b1);
         // Discard edges the PIO latched while reset was being released.
         ST_CLR0:     bus_cmd = avm_wr(PIO_EDGE, 1'b0);
         ST_RD_EDGE:  bus_cmd = avm_rd(PIO_EDGE);
         // Clear immediately behind the read so only edges arriving in this
         // very cycle can be lost (the PIO clears all bits at once).
         ST_CAP_EDGE: begin
            bus_cmd   = avm_wr(PIO_EDGE, 1'b0);
            cap_edges = 1'b1;
         end
         ST_RD_DATA:  bus_cmd = avm_rd(PIO_DATA);
         ST_CAP_DATA: cap_data = 1'b1;
         default:     bus_cmd = avm_nop();
      endcase
   end

   // ------------------------------------------------------------------
   // Event datapath and saturating delivery counter
   // ------------------------------------------------------------------
   always_comb begin
      edges_d     = edges_q;
      data_d      = data_q;
      evt_valid_d = evt_valid_q;
      count_d     = count_q;

      if (cap_edges) begin
         edges_d = avm_readdata_i[DATA_WIDTH-1:0];
      end
      if (cap_event) begin
         data_d      = avm_readdata_i[DATA_WIDTH-1:0];
         evt_valid_d = 1'b1;
      end else if (handshake) begin
         evt_valid_d = 1'b0;
      end
      if (handshake && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edges_q     <= '0;
         data_q      <= '0;
         evt_valid_q <= 1'b0;
         count_q     <= '0;
      end else begin
         edges_q     <= edges_d;
         data_q      <= data_d;
         evt_valid_q <= evt_valid_d;
         count_q     <= count_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs. The bus command is decoded from the state, and the reset
   // state (INIT) already carries the mask write; qualifying with reset_n
   // keeps the bus quiet while reset is held and lets the INIT write appear
   // in the first cycle after release.
   // ------------------------------------------------------------------
   assign avm_chipselect_o = bus_cmd.chipselect & reset_n;
   assign avm_write_n_o    = bus_cmd.write_n | ~reset_n;
   assign avm_address_o    = reset_n ? bus_cmd.address : 2'd0;
   assign avm_writedata_o  = (reset_n && bus_cmd.wr_mask) ? 32'(IRQ_MASK) : 32'd0;

   assign evt_valid_o = evt_valid_q;
   assign evt_edges_o = edges_q;
   assign evt_data_o  = data_q;
   assign evt_count_o = count_q;
   assign busy_o      = reset_n & (state_q != ST_IDLE);

   // Upper read-data bits carry nothing for a narrow PIO.
   generate
      if (DATA_WIDTH < 32) begin : g_rdata_unused
         logic unused_rdata_hi;
         assign unused_rdata_hi = ^avm_readdata_i[31:DATA_WIDTH];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pio_irq_servicer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pio_irq_servicer                                           |
// | Description : Self-checking bench for pio_irq_servicer with a behavioural   |
// |               any-edge PIO slave and an event scoreboard.                   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_pio_irq_servicer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        irq;
   logic [1:0]  avm_addr;
   logic        avm_cs;
   logic        avm_wn;
   logic [31:0] avm_wd;
   logic [31:0] rdata = 32'd0;
   logic        evt_valid;
   logic        evt_ready;
   logic [9:0]  evt_edges;
   logic [9:0]  evt_data;
   logic [15:0] evt_count;
   logic        busy;

   always #5 clk = ~clk;

   pio_irq_servicer #(
      .DATA_WIDTH (10),
      .IRQ_MASK   (10'h3FF),
      .CNT_WIDTH  (16)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .enable_i         (enable),
      .irq_i            (irq),
      .avm_address_o    (avm_addr),
      .avm_chipselect_o (avm_cs),
      .avm_write_n_o    (avm_wn),
      .avm_writedata_o  (avm_wd),
      .avm_readdata_i   (rdata),
      .evt_valid_o      (evt_valid),
      .evt_ready_i      (evt_ready),
      .evt_edges_o      (evt_edges),
      .evt_data_o       (evt_data),
      .evt_count_o      (evt_count),
      .busy_o           (busy)
   );

   // ------------------------------------------------------------------
   // PIO slave model: any-edge capture, clear-all on write to offset 3,
   // registered read data with junk in the unused upper bits.
   // ------------------------------------------------------------------
   logic [9:0] in_port   = 10'h000;
   logic [9:0] in_prev   = 10'h000;
   logic [9:0] edge_cap  = 10'h000;
   logic [9:0] mask_q    = 10'h000;
   logic       irq_force = 1'b0;

   assign irq = (|(edge_cap & mask_q)) | irq_force;

   always @(posedge clk) begin
      in_prev <= in_port;
      if (avm_cs && !avm_wn && avm_addr == 2'd3) edge_cap <= 10'h000;
      else                                       edge_cap <= edge_cap | (in_port ^ in_prev);
      if (avm_cs && !avm_wn && avm_addr == 2'd2) mask_q <= avm_wd[9:0];
      if (avm_cs && avm_wn)
         rdata <= {22'h2AAAAA, (avm_addr == 2'd3) ? edge_cap :
                               (avm_addr == 2'd0) ? in_port : 10'h000};
   end

   // ------------------------------------------------------------------
   // Scoreboard, access log, counters
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [9:0] edges;
      logic [9:0] data;
   } evt_t;

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wd;
   } acc_t;

   typedef struct {
      logic [9:0] pat;
      logic [9:0] exp_edges;
      logic [9:0] exp_data;
   } vec_t;

   evt_t  sb[$];
   acc_t  acc_log[$];
   int    total = 0;
   int    bad   = 0;
   int    valid_cycles = 0;
   logic [15:0] exp_count = 16'd0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Monitor samples 2 time units after the falling edge, once the main
   // process has driven this cycle's inputs.
   always @(negedge clk) begin
      evt_t e;
      #2;
      if (reset_n) begin
         if (avm_cs && !busy) chk("cs_while_idle", 32'd1, 32'd0);
         if (avm_wn && avm_wd != 32'd0) chk("wdata_on_read", avm_wd, 32'd0);
         if (avm_cs) acc_log.push_back('{wr: !avm_wn, addr: avm_addr, wd: avm_wd});
         if (evt_valid) valid_cycles++;
         if (evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_event", {12'd0, evt_edges, evt_data}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("evt_edges", {22'd0, evt_edges}, {22'd0, e.edges});
               chk("evt_data",  {22'd0, evt_data},  {22'd0, e.data});
            end
         end
      end
   end

   task automatic wait_sb_empty(input int lim);
      int n = 0;
      while (sb.size() != 0 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("sb_drain", sb.size(), 32'd0);
   endtask

   task automatic wait_busy(input int lim);
      int n = 0;
      while (!busy && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("wait_busy", {31'd0, busy}, 32'd1);
   endtask

   task automatic chk_service_log(input string tag);
      chk({tag, "_log_len"}, acc_log.size(), 32'd3);
      if (acc_log.size() >= 3) begin
         chk({tag, "_acc0"}, {29'd0, acc_log[0].wr, acc_log[0].addr}, {29'd0, 1'b0, 2'd3});
         chk({tag, "_acc1"}, {29'd0, acc_log[1].wr, acc_log[1].addr}, {29'd0, 1'b1, 2'd3});
         chk({tag, "_acc1_wd"}, acc_log[1].wd, 32'd0);
         chk({tag, "_acc2"}, {29'd0, acc_log[2].wr, acc_log[2].addr}, {29'd0, 1'b0, 2'd0});
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cs"},    {31'd0, avm_cs},    32'd0);
      chk({tag, "_wn"},    {31'd0, avm_wn},    32'd1);
      chk({tag, "_addr"},  {30'd0, avm_addr},  32'd0);
      chk({tag, "_wd"},    avm_wd,             32'd0);
      chk({tag, "_valid"}, {31'd0, evt_valid}, 32'd0);
      chk({tag, "_edges"}, {22'd0, evt_edges}, 32'd0);
      chk({tag, "_data"},  {22'd0, evt_data},  32'd0);
      chk({tag, "_count"}, {16'd0, evt_count}, 32'd0);
      chk({tag, "_busy"},  {31'd0, busy},      32'd0);
   endtask

   task automatic chk_init_write(input string tag);
      chk({tag, "_init_cs"},   {31'd0, avm_cs},   32'd1);
      chk({tag, "_init_wn"},   {31'd0, avm_wn},   32'd0);
      chk({tag, "_init_addr"}, {30'd0, avm_addr}, 32'd2);
      chk({tag, "_init_wd"},   avm_wd,            32'h3FF);
   endtask

   // Drive one pin change, expect one event, wait for delivery.
   task automatic deliver(input logic [9:0] pat, input logic [9:0] ee, input logic [9:0] ed,
                          input logic drop_enable);
      @(negedge clk);
      acc_log.delete();
      valid_cycles = 0;
      in_port = pat;
      sb.push_back('{edges: ee, data: ed});
      exp_count = sat_inc(exp_count);
      if (drop_enable) begin
         wait_busy(20);
         enable = 1'b0;
      end
      wait_sb_empty(60);
      @(negedge clk);
      enable = 1'b1;
      chk("deliver_count", {16'd0, evt_count}, {16'd0, exp_count});
      chk("deliver_idle",  {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[5];
      int   stable_err;
      int   cs_seen;
      int   n;

      vecs[0] = '{pat: 10'h005, exp_edges: 10'h005, exp_data: 10'h005};
      vecs[1] = '{pat: 10'h00F, exp_edges: 10'h00A, exp_data: 10'h00F};
      vecs[2] = '{pat: 10'h3F0, exp_edges: 10'h3FF, exp_data: 10'h3F0};
      vecs[3] = '{pat: 10'h000, exp_edges: 10'h3F0, exp_data: 10'h000};
      vecs[4] = '{pat: 10'h201, exp_edges: 10'h201, exp_data: 10'h201};

      reset_n   = 1'b0;
      enable    = 1'b1;
      evt_ready = 1'b1;

      // ---- reset state and init sequence ----
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      reset_n = 1'b1;
      #1;
      chk_init_write("por");
      @(negedge clk);
      chk("clr0_cs",   {31'd0, avm_cs},   32'd1);
      chk("clr0_wn",   {31'd0, avm_wn},   32'd0);
      chk("clr0_addr", {30'd0, avm_addr}, 32'd3);
      @(negedge clk);
      chk("idle_cs",   {31'd0, avm_cs}, 32'd0);
      chk("idle_busy", {31'd0, busy},   32'd0);
      chk("slave_mask", {22'd0, mask_q}, 32'h3FF);

      // ---- table-driven events with ready held high ----
      for (int i = 0; i < 5; i++) begin
         deliver(vecs[i].pat, vecs[i].exp_edges, vecs[i].exp_data, 1'b0);
         chk("vec_valid_cycles", valid_cycles, 32'd1);
         chk_service_log("vec");
      end

      // ---- backpressure: event held while bit 9 toggles ----
      @(negedge clk);
      evt_ready = 1'b0;
      in_port   = 10'h203;
      sb.push_back('{edges: 10'h002, data: 10'h203});
      exp_count = sat_inc(exp_count);
      n = 0;
      while (!evt_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid", {31'd0, evt_valid}, 32'd1);
      @(negedge clk);
      in_port = 10'h003;
      sb.push_back('{edges: 10'h200, data: 10'h003});
      exp_count = sat_inc(exp_count);
      stable_err = 0;
      cs_seen    = 0;
      repeat (20) begin
         @(negedge clk);
         if (!evt_valid || evt_edges !== 10'h002 || evt_data !== 10'h203) stable_err++;
         if (avm_cs) cs_seen++;
      end
      chk("bp_hold_stable", stable_err, 32'd0);
      chk("bp_no_access",   cs_seen,    32'd0);
      chk("bp_irq_pending", {31'd0, irq}, 32'd1);
      evt_ready = 1'b1;
      wait_sb_empty(60);
      @(negedge clk);
      chk("bp_count", {16'd0, evt_count}, {16'd0, exp_count});

      // ---- spurious irq: edge_capture reads zero ----
      @(negedge clk);
      acc_log.delete();
      valid_cycles = 0;
      irq_force    = 1'b1;
      @(negedge clk);
      irq_force = 1'b0;
      repeat (3) @(negedge clk);
      chk("spur_busy_capdata", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("spur_idle", {31'd0, busy}, 32'd0);
      repeat (5) @(negedge clk);
      chk("spur_no_valid", valid_cycles, 32'd0);
      chk("spur_count", {16'd0, evt_count}, {16'd0, exp_count});
      chk_service_log("spur");

      // ---- enable low blocks new sequences ----
      @(negedge clk);
      acc_log.delete();
      enable  = 1'b0;
      in_port = 10'h013;
      sb.push_back('{edges: 10'h010, data: 10'h013});
      exp_count = sat_inc(exp_count);
      repeat (10) @(negedge clk);
      chk("en_blocked_busy", {31'd0, busy}, 32'd0);
      chk("en_blocked_acc",  acc_log.size(), 32'd0);
      enable = 1'b1;
      wait_sb_empty(60);
      @(negedge clk);
      chk("en_count", {16'd0, evt_count}, {16'd0, exp_count});

      // ---- counter saturation, enable dropped mid-sequence ----
      @(negedge clk);
      force dut.count_q = 16'hFFFE;
      @(negedge clk);
      release dut.count_q;
      exp_count = 16'hFFFE;
      chk("sat_preload", {16'd0, evt_count}, 32'h0000FFFE);
      deliver(10'h012, 10'h001, 10'h012, 1'b1);
      deliver(10'h032, 10'h020, 10'h032, 1'b1);
      deliver(10'h072, 10'h040, 10'h072, 1'b1);
      chk("sat_final", {16'd0, evt_count}, 32'h0000FFFF);

      // ---- asynchronous reset in CAP_DATA ----
      @(negedge clk);
      in_port = 10'h0F2;
      n = 0;
      while (!(avm_cs && avm_wn && avm_addr == 2'd0) && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("mid_rd_data_seen", {31'd0, avm_cs}, 32'd1);
      @(negedge clk);
      chk("mid_capdata_busy", {31'd0, busy}, 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("mid");
      exp_count = 16'd0;
      @(negedge clk);
      @(negedge clk);
      acc_log.delete();
      valid_cycles = 0;
      reset_n = 1'b1;
      #1;
      chk_init_write("mid");
      repeat (8) @(negedge clk);
      chk("mid_log_len", acc_log.size(), 32'd2);
      if (acc_log.size() >= 2) begin
         chk("mid_acc0", {29'd0, acc_log[0].wr, acc_log[0].addr}, {29'd0, 1'b1, 2'd2});
         chk("mid_acc1", {29'd0, acc_log[1].wr, acc_log[1].addr}, {29'd0, 1'b1, 2'd3});
      end
      chk("mid_no_event", valid_cycles, 32'd0);
      chk("mid_count", {16'd0, evt_count}, {16'd0, exp_count});
      chk("mid_sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
